// File: rtl/fwd_sequencer_if.sv
// fwd_sequencer control/status bundle.
// slave = sequencer side, master = environment side.
interface fwd_sequencer_if;
  logic       start;
  logic [3:0] state_in;
  logic       abort;
  logic       bp_done;
  logic [3:0] ctrl;
  logic [3:0] step;
  logic [3:0] st;
  logic       dp_clr;
  logic       busy;
  logic       fwd_done;
  logic       bp_req;
  logic       episode_done;
  logic       err;

  modport slave (
    input  start, state_in, abort, bp_done,
    output ctrl, step, st, dp_clr, busy,
    output fwd_done, bp_req, episode_done, err
  );

  modport master (
    output start, state_in, abort, bp_done,
    input  ctrl, step, st, dp_clr, busy,
    input  fwd_done, bp_req, episode_done, err
  );
endinterface

// File: rtl/fwd_sequencer.sv
// Forward-pass sequencer for one Q-network training step.
// Walks the datapath phases, hands off to backprop, counts steps.
module fwd_sequencer #(
  parameter int N_STATES = 9,
  parameter int MAX_STEP = 15,
  parameter int ACT_LAT  = 2
) (
  input logic           clk,
  input logic           rst,
  fwd_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD    = 4'd1,
    HID_ACC = 4'd2,
    HID_ACT = 4'd3,
    OUT_ACC = 4'd4,
    OUT_ACT = 4'd5,
    STORE   = 4'd6,
    BP_WAIT = 4'd7,
    UPDATE  = 4'd8
  } state_e;

  localparam logic [2:0] LAT_M1 = 3'(ACT_LAT - 1);
  localparam logic [4:0] N_ST   = 5'(N_STATES);
  localparam logic [3:0] MAX_S  = 4'(MAX_STEP);

  state_e     state_q, state_d;
  logic [3:0] step_q, step_d;
  logic [3:0] st_q, st_d;
  logic [2:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       epd_q, epd_d;
  logic       st_ok;

  assign st_ok = {1'b0, bus.state_in} < N_ST;

  // Next-state, step/st bookkeeping and activation wait counter.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    epd_d   = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      step_d  = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (st_ok) begin
              st_d    = bus.state_in;
              state_d = LOAD;
              if (step_q == 4'd0) step_d = 4'd1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        LOAD: state_d = HID_ACC;
        HID_ACC: begin
          state_d = HID_ACT;
          cnt_d   = LAT_M1;
        end
        HID_ACT: begin
          if (cnt_q == 3'd0) state_d = OUT_ACC;
          else cnt_d = cnt_q - 3'd1;
        end
        OUT_ACC: begin
          state_d = OUT_ACT;
          cnt_d   = LAT_M1;
        end
        OUT_ACT: begin
          if (cnt_q == 3'd0) state_d = STORE;
          else cnt_d = cnt_q - 3'd1;
        end
        STORE: state_d = BP_WAIT;
        BP_WAIT: begin
          if (bus.bp_done) state_d = UPDATE;
        end
        UPDATE: begin
          state_d = IDLE;
          if (step_q == MAX_S) begin
            step_d = 4'd0;
            epd_d  = 1'b1;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 4'd0;
      st_q    <= 4'd0;
      cnt_q   <= 3'd0;
      err_q   <= 1'b0;
      epd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      epd_q   <= epd_d;
    end
  end

  assign bus.ctrl         = state_q;
  assign bus.step         = step_q;
  assign bus.st           = st_q;
  assign bus.dp_clr       = state_q == LOAD;
  assign bus.busy         = state_q != IDLE;
  assign bus.fwd_done     = state_q == STORE;
  assign bus.bp_req       = state_q == BP_WAIT;
  assign bus.episode_done = epd_q;
  assign bus.err          = err_q;

endmodule
